inst_envelope: RTL and testbench
================================

INST_ENVELOPE -- requirements
Module: inst_envelope

Interface
REQ-001 SHALL have parameter INSTRUMENT_COUNT, default 3: number of instrument envelope channels.
REQ-002 SHALL have parameter HOLD_FRAMES, default 2, legal range 1..15: frames a new hit is held at full level before decay begins.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock, and all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port h_count  input  11  current video column.
REQ-006 SHALL have port v_count  input  10  current video line.
REQ-007 SHALL have port hit_valid  input  INSTRUMENT_COUNT  one-cycle hit strobe, one bit per instrument.
REQ-008 SHALL have port hit_velocity  input  7  velocity that applies to every bit of hit_valid asserted in the same cycle.
REQ-009 SHALL have port decay  input  10  decay potentiometer value; only bits [9:2] are used.
REQ-010 SHALL have port inst_intensity  output  8 x INSTRUMENT_COUNT (unpacked)  per-instrument intensity; bit 7 means active and bits [6:0] hold the level. This port feeds delay_gen.

Function
REQ-011 SHALL define frame_tick as the single cycle where h_count==0 and v_count==720, one line before delay_gen samples its input.
REQ-012 SHALL keep a 7-bit pending velocity register and a pending flag for each instrument.
- A hit with hit_velocity==0 is ignored.
- For a non-zero hit, pending is set to max(pending, hit_velocity) and the flag is set.
REQ-013 SHALL include a hit that coincides with frame_tick in that tick's pending value.
- The pending register and flag then clear on that same tick.
REQ-014 SHALL run a 3-state FSM per instrument with states IDLE, HOLD and DECAY.
- Each channel has a 7-bit level and a 4-bit hold_cnt.
- Transitions occur only on frame_tick.
REQ-015 SHALL, on frame_tick with the pending flag set and in any state, load level=pending, set hold_cnt=HOLD_FRAMES and enter HOLD.
- A retrigger overrides any decay step scheduled for that tick.
REQ-016 SHALL, on frame_tick in HOLD with no pending hit:
- if hold_cnt==1, go to DECAY;
- otherwise decrement hold_cnt;
- level is unchanged in both cases.
REQ-017 SHALL, on frame_tick in DECAY with no pending hit:
- set level=(level*decay[9:2])>>8 using a 15-bit product;
- go to IDLE when the result is 0.
- The result is strictly decreasing because the factor is at most 255.
REQ-018 SHALL leave level at 0 in IDLE, with no action on a tick that has no pending hit.
REQ-019 SHALL drive inst_intensity[i] as 8'h00 when level==0, otherwise {1'b1, level}.
- The output is registered and updates only in the cycle after frame_tick (1-cycle latency).
- It is stable for the rest of the frame.
REQ-020 SHALL treat each channel independently; simultaneous hits on several channels all register.

Reset
REQ-021 SHALL, while rst is high, clear every inst_intensity output, level, hold_cnt and pending register/flag, and set every FSM to IDLE.
REQ-022 SHALL discard hits received in the same cycle as rst.
- Reset in the middle of HOLD or DECAY aborts the envelope with no residual output.

Configuration
REQ-023 SHALL use the macro INST_ENVELOPE_HOLD_EN to select the hold behaviour.
- Defined: HOLD behaves per REQ-015/016.
- Undefined: a load enters DECAY directly, the HOLD state and hold_cnt are not built, HOLD_FRAMES is ignored, and the first decay step happens on the tick after the load.

Verification
REQ-024 SHALL cover the basic hold-and-decay sequence.
- Stimulus: HOLD_EN defined, decay=10'h3FC, hit_valid=3'b001 with vel 100 at line 100.
- Response: ch0=8'hE4 after the next tick, unchanged for 2 more ticks, then 8'hE3 (99), then 8'hE2 (98).
REQ-025 SHALL cover max-merging of hits within one frame.
- Stimulus: ch1 hits with vel 40 then vel 90 then vel 20 within one frame.
- Response: ch1=8'hDA after the tick.
REQ-026 SHALL cover a hit coinciding with the tick and a zero-velocity hit.
- Stimulus: hit with vel 5 on ch2 exactly at the frame_tick cycle.
- Response: ch2=8'h85 after that tick.
- Stimulus: vel 0 hit on ch2.
- Response: no change.
REQ-027 SHALL cover fast decay to zero.
- Stimulus: decay=0 in DECAY with level 50.
- Response: output 8'h00 and IDLE after the next tick.
- Stimulus: a retrigger with vel 10 on that same tick.
- Response: 8'h8A and HOLD instead.
REQ-028 SHALL cover reset mid-envelope.
- Stimulus: rst pulsed for 1 cycle while ch0=8'hE4 with a pending hit.
- Response: all outputs 8'h00 next cycle and no output on the following tick.
REQ-029 SHALL cover the HOLD_EN undefined build.
- Stimulus: decay=10'h200, hit vel 100.
- Response: 8'hE4, then 8'hB2 (50), then 8'h99 (25) on successive ticks.

Source files
------------

// File: rtl/inst_envelope_if.sv
// Signal bundle for inst_envelope: raster position, hit strobes, decay setting and per-instrument intensity.
interface inst_envelope_if #(
   parameter int unsigned INSTRUMENT_COUNT = 3
);
   logic [10:0] h_count;
   logic [9:0]  v_count;
   logic [INSTRUMENT_COUNT-1:0] hit_valid;
   logic [6:0]  hit_velocity;
   logic [9:0]  decay;
   logic [7:0]  inst_intensity [INSTRUMENT_COUNT];

   modport master (
      output h_count, v_count, hit_valid, hit_velocity, decay,
      input  inst_intensity
   );

   modport slave (
      input  h_count, v_count, hit_valid, hit_velocity, decay,
      output inst_intensity
   );
endinterface

// File: rtl/inst_envelope.sv
// Per-instrument hold/decay envelope, stepped once per frame at line 720, column 0.
// Macro INST_ENVELOPE_HOLD_EN builds the HOLD stage; without it a hit decays from the next frame on.
module inst_envelope #(
   parameter int unsigned INSTRUMENT_COUNT = 3,
   parameter int unsigned HOLD_FRAMES      = 2
) (
   input logic            clk,
   input logic            rst,
   inst_envelope_if.slave bus
);

`ifdef INST_ENVELOPE_HOLD_EN
   typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;
`else
   typedef enum logic {IDLE, DECAY} state_t;
   localparam int unsigned UNUSED_HOLD_FRAMES = HOLD_FRAMES;
`endif

   logic       frame_tick;
   logic [7:0] decay_f;
   logic       unused_decay_bits;

   assign frame_tick        = (bus.h_count == 11'd0) && (bus.v_count == 10'd720);
   assign decay_f           = bus.decay[9:2];
   assign unused_decay_bits = ^bus.decay[1:0];

   for (genvar g = 0; g < INSTRUMENT_COUNT; g++) begin : g_chan
      state_t      state_q, state_d;
      logic [6:0]  level_q, level_d;
      logic [6:0]  pend_q, pend_d;
      logic        pflag_q, pflag_d;
      logic [7:0]  out_q, out_d;
      logic        hit_ok;
      logic [6:0]  merged;
      logic        mflag;
      logic [14:0] product;
`ifdef INST_ENVELOPE_HOLD_EN
      logic [3:0]  hold_q, hold_d;
`endif

      assign hit_ok  = bus.hit_valid[g] && (bus.hit_velocity != 7'd0);
      assign merged  = (hit_ok && (bus.hit_velocity > pend_q)) ? bus.hit_velocity : pend_q;
      assign mflag   = pflag_q | hit_ok;
      assign product = {8'd0, level_q} * {7'd0, decay_f};

      // A hit landing on the tick itself is folded in via merged/mflag before the pending state clears.
      always_comb begin
         state_d = state_q;
         level_d = level_q;
         pend_d  = merged;
         pflag_d = mflag;
         out_d   = out_q;
`ifdef INST_ENVELOPE_HOLD_EN
         hold_d  = hold_q;
`endif
         if (frame_tick) begin
            pend_d  = '0;
            pflag_d = 1'b0;
            if (mflag) begin
               level_d = merged;
`ifdef INST_ENVELOPE_HOLD_EN
               hold_d  = 4'(HOLD_FRAMES);
               state_d = HOLD;
`else
               state_d = DECAY;
`endif
            end else begin
               case (state_q)
`ifdef INST_ENVELOPE_HOLD_EN
                  HOLD: begin
                     if (hold_q == 4'd1) state_d = DECAY;
                     else                hold_d  = hold_q - 4'd1;
                  end
`endif
                  DECAY: begin
                     level_d = product[14:8];
                     if (product[14:8] == 7'd0) state_d = IDLE;
                  end
                  default: ;
               endcase
            end
            out_d = (level_d == 7'd0) ? 8'h00 : {1'b1, level_d};
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
            pend_q  <= '0;
            pflag_q <= 1'b0;
            out_q   <= '0;
`ifdef INST_ENVELOPE_HOLD_EN
            hold_q  <= '0;
`endif
         end else begin
            state_q <= state_d;
            level_q <= level_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            out_q   <= out_d;
`ifdef INST_ENVELOPE_HOLD_EN
            hold_q  <= hold_d;
`endif
         end
      end

      assign bus.inst_intensity[g] = out_q;
   end

endmodule

// File: tb/tb_inst_envelope.sv
// Directed checks of inst_envelope hold/decay, hit merging, tick boundaries and reset.
module tb_inst_envelope;
   localparam int unsigned N = 3;
`ifdef INST_ENVELOPE_HOLD_EN
   localparam int unsigned HT = 2;
`else
   localparam int unsigned HT = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   inst_envelope_if #(.INSTRUMENT_COUNT(N)) bus ();

   inst_envelope #(.INSTRUMENT_COUNT(N), .HOLD_FRAMES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [10:0] h, input logic [9:0] v,
                       input logic [N-1:0] m, input logic [6:0] vel);
      bus.h_count      = h;
      bus.v_count      = v;
      bus.hit_valid    = m;
      bus.hit_velocity = vel;
      @(posedge clk);
      #1;
      bus.hit_valid    = '0;
      bus.hit_velocity = '0;
      bus.h_count      = 11'd5;
      bus.v_count      = 10'd100;
   endtask

   task automatic hit(input logic [N-1:0] m, input logic [6:0] vel);
      step(11'd200, 10'd100, m, vel);
   endtask

   task automatic tick_hit(input logic [N-1:0] m, input logic [6:0] vel);
      step(11'd0, 10'd720, m, vel);
   endtask

   task automatic tick();
      step(11'd0, 10'd720, '0, 7'd0);
   endtask

   task automatic idle();
      step(11'd5, 10'd100, '0, 7'd0);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      idle();
      rst = 1'b0;
   endtask

   initial begin
      rst              = 1'b1;
      bus.h_count      = 11'd5;
      bus.v_count      = 10'd100;
      bus.hit_valid    = '0;
      bus.hit_velocity = '0;
      bus.decay        = 10'h000;
      idle();
      hit(3'b111, 7'd100);
      rst = 1'b0;
      chk("rst_ch0", bus.inst_intensity[0], 8'h00);
      chk("rst_ch1", bus.inst_intensity[1], 8'h00);
      chk("rst_ch2", bus.inst_intensity[2], 8'h00);
      tick();
      chk("rst_hit_discarded", bus.inst_intensity[0], 8'h00);

      // hold then decay with factor 255
      bus.decay = 10'h3FC;
      hit(3'b001, 7'd100);
      step(11'd1, 10'd720, '0, 7'd0);
      chk("h1_not_tick", bus.inst_intensity[0], 8'h00);
      step(11'd0, 10'd719, '0, 7'd0);
      chk("v719_not_tick", bus.inst_intensity[0], 8'h00);
      tick();
      chk("load_e4", bus.inst_intensity[0], 8'hE4);
      idle();
      chk("stable_in_frame", bus.inst_intensity[0], 8'hE4);
      for (int unsigned k = 0; k < HT; k++) begin
         tick();
         chk("hold_e4", bus.inst_intensity[0], 8'hE4);
      end
      tick();
      chk("decay_e3", bus.inst_intensity[0], 8'hE3);
      tick();
      chk("decay_e2", bus.inst_intensity[0], 8'hE2);

      // max merge in one frame
      hit(3'b010, 7'd40);
      hit(3'b010, 7'd90);
      hit(3'b010, 7'd20);
      tick();
      chk("max_merge", bus.inst_intensity[1], 8'hDA);
      chk("decay_e1", bus.inst_intensity[0], 8'hE1);

      // hit on the tick cycle, then a zero-velocity hit on the tick
      tick_hit(3'b100, 7'd5);
      chk("tick_hit", bus.inst_intensity[2], 8'h85);
      tick_hit(3'b100, 7'd0);
      chk("zero_vel_tick", bus.inst_intensity[2], (HT > 0) ? 8'h85 : 8'h84);

      // simultaneous hits and zero velocity on an idle channel
      do_rst();
      hit(3'b110, 7'd33);
      hit(3'b001, 7'd0);
      tick();
      chk("multi_ch1", bus.inst_intensity[1], 8'hA1);
      chk("multi_ch2", bus.inst_intensity[2], 8'hA1);
      chk("zero_vel_idle", bus.inst_intensity[0], 8'h00);

      // fast decay to zero from level 50
      do_rst();
      bus.decay = 10'h3FC;
      hit(3'b001, 7'd50);
      tick();
      chk("load_b2", bus.inst_intensity[0], 8'hB2);
      for (int unsigned k = 0; k < HT; k++) tick();
      bus.decay = 10'h000;
      tick();
      chk("fast_decay", bus.inst_intensity[0], 8'h00);

      // retrigger on the tick that would have zeroed the level
      do_rst();
      bus.decay = 10'h3FC;
      hit(3'b001, 7'd50);
      tick();
      for (int unsigned k = 0; k < HT; k++) tick();
      bus.decay = 10'h000;
      tick_hit(3'b001, 7'd10);
      chk("retrigger", bus.inst_intensity[0], 8'h8A);
      tick();
      chk("retrig_after", bus.inst_intensity[0], (HT > 0) ? 8'h8A : 8'h00);

      // reset mid-envelope with a pending hit
      do_rst();
      bus.decay = 10'h3FC;
      hit(3'b001, 7'd100);
      tick();
      chk("pre_rst_e4", bus.inst_intensity[0], 8'hE4);
      hit(3'b001, 7'd70);
      do_rst();
      chk("mid_rst_ch0", bus.inst_intensity[0], 8'h00);
      chk("mid_rst_ch1", bus.inst_intensity[1], 8'h00);
      chk("mid_rst_ch2", bus.inst_intensity[2], 8'h00);
      tick();
      chk("post_rst_tick", bus.inst_intensity[0], 8'h00);

      // half-rate decay
      bus.decay = 10'h200;
      hit(3'b001, 7'd100);
      tick();
      chk("half_load", bus.inst_intensity[0], 8'hE4);
      for (int unsigned k = 0; k < HT; k++) begin
         tick();
         chk("half_hold", bus.inst_intensity[0], 8'hE4);
      end
      tick();
      chk("half_b2", bus.inst_intensity[0], 8'hB2);
      tick();
      chk("half_99", bus.inst_intensity[0], 8'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
